// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: alignment check, one outstanding req/gnt/rvalid
// data-bus transaction, and aligned/extended load data or exception cause back to the pipeline.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  type_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        exc_o,
    output logic [4:0]  exc_cause_o,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID} state_t;

    localparam logic [1:0] BYTE      = 2'd0;
    localparam logic [1:0] HALF_WORD = 2'd1;

    localparam logic [4:0] EXC_CAUSE_LD_MISAL = 5'd4;
    localparam logic [4:0] EXC_CAUSE_LD_FAULT = 5'd5;
    localparam logic [4:0] EXC_CAUSE_ST_MISAL = 5'd6;
    localparam logic [4:0] EXC_CAUSE_ST_FAULT = 5'd7;

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              we_q, sign_q;
    logic [1:0]        type_q, off_q;
    logic [29:0]       addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              done_q, exc_q;
    logic [4:0]        cause_q;
    logic [31:0]       rdata_q;

    logic              accept, misaligned, timeout;
    logic [3:0]        be_n;
    logic [31:0]       wdata_n, shifted, load_ext;

    assign accept  = req_i && (state == IDLE);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_comb begin
        misaligned = 1'b0;
        be_n       = 4'b1111;
        wdata_n    = wdata_i;
        case (type_i)
            BYTE: begin
                be_n    = 4'b0001 << addr_i[1:0];
                wdata_n = {4{wdata_i[7:0]}};
            end
            HALF_WORD: begin
                misaligned = addr_i[0];
                be_n       = 4'b0011 << addr_i[1:0];
                wdata_n    = {2{wdata_i[15:0]}};
            end
            default: misaligned = (addr_i[1:0] != 2'b00);
        endcase
    end

    // The addressed lane is shifted down to bit 0 before extension.
    always_comb begin
        shifted  = dmem_rdata_i >> {off_q, 3'b000};
        load_ext = shifted;
        case (type_q)
            BYTE:      load_ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            HALF_WORD: load_ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default:   load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (accept && !misaligned) state_next = REQ;
            REQ:         if (dmem_gnt_i || timeout) state_next = (dmem_gnt_i) ? WAIT_RVALID : IDLE;
            WAIT_RVALID: if (dmem_rvalid_i || timeout) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o    = (state == IDLE);
        dmem_req_o = (state == REQ);
    end

    // Completion flags and load data live for exactly one cycle after the finishing event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            type_q  <= 2'b00;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= '0;
            rdata_q <= '0;
        end else begin
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= '0;
            rdata_q <= '0;
            if ((state != IDLE) && (state_next == state)) cnt <= cnt + CNT_W'(1);
            else                                          cnt <= '0;
            case (state)
                IDLE: if (accept) begin
                    we_q    <= we_i;
                    sign_q  <= sign_ext_i;
                    type_q  <= type_i;
                    off_q   <= addr_i[1:0];
                    addr_q  <= addr_i[31:2];
                    be_q    <= be_n;
                    wdata_q <= wdata_n;
                    if (misaligned) begin
                        done_q  <= 1'b1;
                        exc_q   <= 1'b1;
                        cause_q <= we_i ? EXC_CAUSE_ST_MISAL : EXC_CAUSE_LD_MISAL;
                    end
                end
                REQ: if (!dmem_gnt_i && timeout) begin
                    done_q  <= 1'b1;
                    exc_q   <= 1'b1;
                    cause_q <= we_q ? EXC_CAUSE_ST_FAULT : EXC_CAUSE_LD_FAULT;
                end
                WAIT_RVALID: begin
                    if (dmem_rvalid_i) begin
                        done_q <= 1'b1;
                        if (!we_q) rdata_q <= load_ext;
                    end else if (timeout) begin
                        done_q  <= 1'b1;
                        exc_q   <= 1'b1;
                        cause_q <= we_q ? EXC_CAUSE_ST_FAULT : EXC_CAUSE_LD_FAULT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_o       = done_q;
    assign exc_o        = exc_q;
    assign exc_cause_o  = cause_q;
    assign rdata_o      = rdata_q;
    assign dmem_addr_o  = {addr_q, 2'b00};
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized transactions with random
// grant/response delays, checked against a size/offset arithmetic model of the access.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, we_i, sign_ext_i;
    logic [1:0]  type_i;
    logic [31:0] addr_i, wdata_i;
    logic        ready_o, done_o, exc_o;
    logic [31:0] rdata_o;
    logic [4:0]  exc_cause_o;
    logic        dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_be_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .type_i(type_i),
        .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o),
        .done_o(done_o), .rdata_o(rdata_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
        .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] typ, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wd);
        checkOutput("ready_before_accept", 32'(ready_o), 32'd1);
        req_i      = 1'b1;
        we_i       = we;
        type_i     = typ;
        sign_ext_i = sgn;
        addr_i     = addr;
        wdata_i    = wd;
        tick();
        req_i      = 1'b0;
        we_i       = $urandom_range(0, 1);
        addr_i     = $urandom;
        wdata_i    = $urandom;
    endtask

    // g: REQ cycle index in which gnt arrives; r: WAIT cycle index in which rvalid arrives.
    task automatic runTransaction(input logic we, input logic [1:0] typ, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input int g, input int r, input logic [31:0] bus_rdata);
        int          nbytes, off;
        bit          mis, fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, mask, exp_load;

        nbytes = (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : 4;
        off    = int'(addr[1:0]);
        mis    = (off % nbytes) != 0;
        exp_be = 4'(((1 << nbytes) - 1) << off);
        if (nbytes == 1)      exp_wdata = {24'd0, wd[7:0]} * 32'h01010101;
        else if (nbytes == 2) exp_wdata = {16'd0, wd[15:0]} * 32'h00010001;
        else                  exp_wdata = wd;
        mask     = (nbytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        exp_load = (bus_rdata >> (8 * off)) & mask;
        if (sgn && nbytes < 4 && exp_load[8 * nbytes - 1]) exp_load = exp_load | ~mask;

        applyStimulus(we, typ, sgn, addr, wd);

        if (mis) begin
            checkOutput("misal_no_req", 32'(dmem_req_o), 32'd0);
            checkOutput("misal_ready", 32'(ready_o), 32'd1);
            checkOutput("misal_done", 32'(done_o), 32'd1);
            checkOutput("misal_exc", 32'(exc_o), 32'd1);
            checkOutput("misal_cause", 32'(exc_cause_o), we ? 32'd6 : 32'd4);
            checkOutput("misal_rdata", rdata_o, 32'd0);
            return;
        end

        fault = 1'b0;
        for (int i = 0; ; i++) begin
            checkOutput("req_active", 32'(dmem_req_o), 32'd1);
            checkOutput("req_ready_low", 32'(ready_o), 32'd0);
            checkOutput("req_done_low", 32'(done_o), 32'd0);
            checkOutput("req_addr", dmem_addr_o, addr & 32'hFFFFFFFC);
            checkOutput("req_we", 32'(dmem_we_o), 32'(we));
            checkOutput("req_be", 32'(dmem_be_o), 32'(exp_be));
            if (we) checkOutput("req_wdata", dmem_wdata_o, exp_wdata);
            dmem_gnt_i    = (i == g);
            dmem_rvalid_i = $urandom_range(0, 1);
            dmem_rdata_i  = $urandom;
            tick();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (i == g) break;
            if (i == TO - 1) begin
                fault = 1'b1;
                break;
            end
        end

        if (!fault) begin
            for (int i = 0; ; i++) begin
                checkOutput("wait_no_req", 32'(dmem_req_o), 32'd0);
                checkOutput("wait_ready_low", 32'(ready_o), 32'd0);
                checkOutput("wait_done_low", 32'(done_o), 32'd0);
                dmem_rvalid_i = (i == r);
                dmem_rdata_i  = (i == r) ? bus_rdata : $urandom;
                dmem_gnt_i    = $urandom_range(0, 1);
                tick();
                dmem_rvalid_i = 1'b0;
                dmem_gnt_i    = 1'b0;
                if (i == r) break;
                if (i == TO - 1) begin
                    fault = 1'b1;
                    break;
                end
            end
        end

        checkOutput("done_pulse", 32'(done_o), 32'd1);
        checkOutput("done_ready", 32'(ready_o), 32'd1);
        checkOutput("done_no_req", 32'(dmem_req_o), 32'd0);
        checkOutput("done_exc", 32'(exc_o), 32'(fault));
        checkOutput("done_cause", 32'(exc_cause_o), fault ? (we ? 32'd7 : 32'd5) : 32'd0);
        checkOutput("done_rdata", rdata_o, (!fault && !we) ? exp_load : 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        req_i = 1'b0; we_i = 1'b0; type_i = 2'd0; sign_ext_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        tick();
        tick();
        rst_i = 1'b0;

        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_exc", 32'(exc_o), 32'd0);
        checkOutput("rst_cause", 32'(exc_cause_o), 32'd0);
        checkOutput("rst_rdata", rdata_o, 32'd0);
        checkOutput("rst_req", 32'(dmem_req_o), 32'd0);
        checkOutput("rst_addr", dmem_addr_o, 32'd0);
        checkOutput("rst_we", 32'(dmem_we_o), 32'd0);
        checkOutput("rst_be", 32'(dmem_be_o), 32'd0);
        checkOutput("rst_wdata", dmem_wdata_o, 32'd0);

        runTransaction(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        runTransaction(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80123456);
        runTransaction(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80123456);
        runTransaction(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 0, 0, 32'h0);
        runTransaction(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 0, 32'h0);
        runTransaction(1'b1, 2'd1, 1'b0, 32'h101, 32'h5555, 0, 0, 32'h0);
        runTransaction(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 100, 0, 32'h0);
        runTransaction(0, 2'd1, 1'b1, 32'h40E, 32'h0, 1, 100, 32'h9ABC0000);
        runTransaction(1'b0, 2'd1, 1'b1, 32'h40E, 32'h0, TO - 1, TO - 1, 32'h9ABC0000);
        tick();
        checkOutput("idle_done_low", 32'(done_o), 32'd0);

        applyStimulus(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput("abort_ready", 32'(ready_o), 32'd1);
        checkOutput("abort_req", 32'(dmem_req_o), 32'd0);
        checkOutput("abort_done", 32'(done_o), 32'd0);
        checkOutput("abort_be", 32'(dmem_be_o), 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h12345678;
        dmem_gnt_i    = 1'b1;
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i    = 1'b0;
        checkOutput("late_rvalid_done", 32'(done_o), 32'd0);
        checkOutput("late_rvalid_rdata", rdata_o, 32'd0);
        checkOutput("late_rvalid_exc", 32'(exc_o), 32'd0);
        checkOutput("late_gnt_no_req", 32'(dmem_req_o), 32'd0);

        for (int n = 0; n < 80; n++) begin
            runTransaction(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), $urandom, $urandom,
                           $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                checkOutput("gap_done_low", 32'(done_o), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
